// File: rtl/spmv_row_accumulator.sv
// Per-row reduction of a row-tagged product stream into one (row, sum) result per matrix row.
// Optional macro SPMV_ACC_SATURATE_EN: clamp the accumulator on signed overflow instead of wrapping.
module spmv_row_accumulator #(
  parameter int LENGTH     = 16,
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH,
  parameter int ADDR_WIDTH = $clog2(LENGTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ACC_WIDTH-1:0]  in_data,
  input  logic [ADDR_WIDTH-1:0] in_row,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [ACC_WIDTH-1:0]  out_data,
  output logic                  out_last,
  output logic                  done,
  output logic                  err
);

  // state | meaning
  // IDLE  | waiting for start
  // ACC   | accumulating beats of cur_row, emitting gap rows when the row index jumps
  // TAIL  | input finished, emitting cur_row..LENGTH-1
  // DRAIN | waiting for the out_last handshake
  typedef enum logic [1:0] {IDLE, ACC, TAIL, DRAIN} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(LENGTH-1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] cur_row;
  logic [ACC_WIDTH-1:0]  acc;
  logic [ACC_WIDTH-1:0]  sum_wrap;
  logic [ACC_WIDTH-1:0]  acc_next;
  logic                  slot_free;

  assign slot_free = !out_valid || out_ready;
  assign sum_wrap  = acc + in_data;

`ifdef SPMV_ACC_SATURATE_EN
  logic ovf;
  assign ovf      = (acc[ACC_WIDTH-1] == in_data[ACC_WIDTH-1]) &&
                    (sum_wrap[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
  assign acc_next = !ovf ? sum_wrap :
                    acc[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                     : {1'b0, {(ACC_WIDTH-1){1'b1}}};
`else
  assign acc_next = sum_wrap;
`endif

  // Matching beats are summed; backward beats are taken and dropped.
  assign in_ready = (state == ACC) && !flush && in_valid && (in_row <= cur_row);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_row   <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (start) begin
            cur_row <= '0;
            acc     <= '0;
            err     <= 1'b0;
            state   <= ACC;
          end
        end
        ACC: begin
          if (flush) begin
            state <= TAIL;
          end else if (in_valid) begin
            if (in_row == cur_row) begin
              acc <= acc_next;
              if (in_last) state <= TAIL;
            end else if (in_row < cur_row) begin
              err <= 1'b1;
              // a dropped final beat still ends the input so the pass completes
              if (in_last) state <= TAIL;
            end else if (slot_free) begin
              out_valid <= 1'b1;
              out_addr  <= cur_row;
              out_data  <= acc;
              out_last  <= 1'b0;
              cur_row   <= cur_row + 1'b1;
              acc       <= '0;
            end
          end
        end
        TAIL: begin
          if (slot_free) begin
            out_valid <= 1'b1;
            out_addr  <= cur_row;
            out_data  <= acc;
            out_last  <= (cur_row == LAST_ROW);
            if (cur_row == LAST_ROW) begin
              state <= DRAIN;
            end else begin
              cur_row <= cur_row + 1'b1;
              acc     <= '0;
            end
          end
        end
        DRAIN: begin
          if (out_valid && out_ready && out_last) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spmv_row_accumulator.sv
// Bench for spmv_row_accumulator at LENGTH=4, ACC_WIDTH=16: vector table, hand sequences and random passes.
module tb_spmv_row_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, flush = 1'b0;
  logic        in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic [15:0] in_data = '0;
  logic [1:0]  in_row = '0;
  logic        out_valid, out_ready, out_last, done, err;
  logic [1:0]  out_addr;
  logic [15:0] out_data;

  spmv_row_accumulator #(.LENGTH(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_row(in_row),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .out_last(out_last),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [1:0] row; logic [15:0] data; } beat_t;
  typedef struct packed { logic [1:0] addr; logic [15:0] data; logic last; } res_t;
  typedef struct packed {
    logic [3:0]        n;
    logic              fl;
    beat_t [7:0]       beats;
    logic [3:0][15:0]  exp;
    logic              exp_err;
  } vec_t;

`ifdef SPMV_ACC_SATURATE_EN
  localparam logic [15:0] SAT_EXP = 16'h7FFF;
`else
  localparam logic [15:0] SAT_EXP = 16'h8000;
`endif

  vec_t        tbl [6];
  beat_t       beat_q [$];
  res_t        res_q [$];
  logic [15:0] exp_s [4];
  bit          exp_e;
  int          checks = 0, errors = 0, done_cnt = 0;
  bit          bp_rand = 0, hold_low = 0;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) res_q.push_back({out_addr, out_data, out_last});
    if (done) done_cnt++;
  end

  initial out_ready = 1'b1;
  always @(posedge clk) begin
    #2;
    out_ready = bp_rand ? 1'($urandom_range(0, 1)) : !hold_low;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] acc_add(input logic [15:0] a, input logic [15:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
`ifdef SPMV_ACC_SATURATE_EN
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`endif
    return s[15:0];
  endfunction

  // Reference: rows must be non-decreasing; any beat below the highest row seen is lost.
  task automatic model_ref(output int mx);
    mx = 0;
    exp_e = 0;
    for (int r = 0; r < 4; r++) exp_s[r] = '0;
    foreach (beat_q[i]) begin
      if (int'(beat_q[i].row) < mx) exp_e = 1;
      else begin
        mx = int'(beat_q[i].row);
        exp_s[mx] = acc_add(exp_s[mx], beat_q[i].data);
      end
    end
  endtask

  task automatic load_vec(input int k);
    beat_q.delete();
    for (int i = 0; i < int'(tbl[k].n); i++) beat_q.push_back(tbl[k].beats[i]);
    for (int r = 0; r < 4; r++) exp_s[r] = tbl[k].exp[r];
    exp_e = tbl[k].exp_err;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_beat(input beat_t b, input bit last, output int stalls);
    bit got = 0;
    in_valid = 1'b1; in_row = b.row; in_data = b.data; in_last = last;
    stalls = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (in_ready) begin got = 1; break; end
      stalls++;
    end
    check("beat_accept", 32'(got), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic hold_check();
    bit seen = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (out_valid && !out_ready && out_addr == 2'd1) begin seen = 1; break; end
    end
    check("hold_seen", 32'(seen), 32'd1);
    if (seen) begin
      for (int k = 0; k < 5; k++) begin
        if (k > 0) @(negedge clk);
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_addr", 32'(out_addr), 32'd1);
        check("hold_data", 32'(out_data), 32'd7);
        if (k > 0) check("hold_in_ready", 32'(in_ready), 32'd0);
      end
    end
    hold_low = 0;
  endtask

  task automatic run_pass(input bit use_flush, input bit hold, output int stall1);
    int st;
    stall1 = 0;
    res_q.delete();
    done_cnt = 0;
    pulse_start();
    fork
      begin
        foreach (beat_q[i]) begin
          drive_beat(beat_q[i], !use_flush && (i == beat_q.size() - 1), st);
          if (i == 1) stall1 = st;
          if (hold && i == 3) hold_low = 1;
        end
        if (use_flush) begin
          flush = 1'b1;
          @(posedge clk); #1;
          flush = 1'b0;
        end
      end
      begin
        if (hold) hold_check();
      end
    join
    for (int c = 0; c < 300 && done_cnt == 0; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("result_count", 32'(res_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < res_q.size(); i++) begin
      check($sformatf("row%0d_addr", i), 32'(res_q[i].addr), 32'(i));
      check($sformatf("row%0d_data", i), 32'(res_q[i].data), 32'(exp_s[i]));
      check($sformatf("row%0d_last", i), 32'(res_q[i].last), 32'(i == 3));
    end
    check("err_flag", 32'(err), 32'(exp_e));
  endtask

  initial begin
    int st, mx, n, cur;
    bit use_flush;
    beat_t b;

    // backward row -> dropped, err set; rows 0,1,3 zero
    tbl[0].n = 2; tbl[0].fl = 1; tbl[0].exp_err = 1;
    tbl[0].beats[0] = {2'd2, 16'd4}; tbl[0].beats[1] = {2'd1, 16'd9};
    tbl[0].exp = {16'd0, 16'd4, 16'd0, 16'd0};
    tbl[1].n = 6; tbl[1].fl = 0; tbl[1].exp_err = 0;
    tbl[1].beats[0] = {2'd0, 16'd1}; tbl[1].beats[1] = {2'd0, 16'd2};
    tbl[1].beats[2] = {2'd1, 16'd3}; tbl[1].beats[3] = {2'd1, 16'd4};
    tbl[1].beats[4] = {2'd2, 16'd5}; tbl[1].beats[5] = {2'd3, 16'd6};
    tbl[1].exp = {16'd6, 16'd5, 16'd7, 16'd3};
    tbl[2].n = 2; tbl[2].fl = 0; tbl[2].exp_err = 0;
    tbl[2].beats[0] = {2'd0, 16'd5}; tbl[2].beats[1] = {2'd3, 16'd7};
    tbl[2].exp = {16'd7, 16'd0, 16'd0, 16'd5};
    tbl[3].n = 2; tbl[3].fl = 0; tbl[3].exp_err = 0;
    tbl[3].beats[0] = {2'd0, 16'h7FFF}; tbl[3].beats[1] = {2'd0, 16'h0001};
    tbl[3].exp = {16'd0, 16'd0, 16'd0, SAT_EXP};
    tbl[4].n = 3; tbl[4].fl = 0; tbl[4].exp_err = 0;
    tbl[4].beats[0] = {2'd1, 16'hFFFD}; tbl[4].beats[1] = {2'd1, 16'hFFFF};
    tbl[4].beats[2] = {2'd2, 16'h000A};
    tbl[4].exp = {16'd0, 16'h000A, 16'hFFFC, 16'd0};
    tbl[5].n = 0; tbl[5].fl = 1; tbl[5].exp_err = 0;
    tbl[5].exp = {16'd0, 16'd0, 16'd0, 16'd0};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    @(posedge clk); #1;

    for (int k = 0; k < 6; k++) begin
      load_vec(k);
      run_pass(tbl[k].fl, 0, st);
      if (k == 2) check("gap_stall_cycles", 32'(st), 32'd3);
    end

    // backpressure at row 1
    load_vec(1);
    run_pass(0, 1, st);

    // reset mid-pass after row 1 emitted
    res_q.delete();
    pulse_start();
    for (int i = 0; i < 5; i++) drive_beat(tbl[1].beats[i], 0, st);
    check("pre_reset_rows", 32'(res_q.size() >= 2), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = 1'b1; in_row = 2'd0;
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    load_vec(1);
    run_pass(0, 0, st);

    // random passes with random backpressure
    bp_rand = 1;
    for (int p = 0; p < 25; p++) begin
      beat_q.delete();
      n = $urandom_range(1, 8);
      cur = 0;
      for (int i = 0; i < n; i++) begin
        int r;
        r = $urandom_range(0, 9);
        if (r == 0 && cur > 0) b.row = 2'($urandom_range(0, cur - 1));
        else begin
          if (r >= 5) cur = (cur + int'($urandom_range(1, 2)) > 3) ? 3 : cur + int'($urandom_range(1, 2));
          b.row = 2'(cur);
        end
        b.data = ($urandom_range(0, 3) == 0) ? 16'h7FF0 + 16'($urandom_range(0, 31)) : 16'($urandom);
        beat_q.push_back(b);
      end
      model_ref(mx);
      use_flush = (int'(beat_q[beat_q.size() - 1].row) < mx) || ($urandom_range(0, 3) == 0);
      run_pass(use_flush, 0, st);
    end
    bp_rand = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/spmv_row_accumulator.md
Name: spmv_row_accumulator

Overview:
- Downstream stage of the SpMV kernel's product network: consumes a stream of per-nonzero products tagged with their row index and reduces them per row.
- Emits exactly one (row, sum) result per matrix row, 0..LENGTH-1, in order, as writes toward x_n.
- Rows with no nonzeros are emitted as zero.
- Single lane, integer datapath; one product accepted per cycle while the row is unchanged.

Parameters:
- LENGTH, 16, number of matrix rows (output vector length).
- DATA_WIDTH, 32, operand width feeding the product stage.
- ACC_WIDTH, 2*DATA_WIDTH, product/accumulator width.
- ADDR_WIDTH, $clog2(LENGTH), row index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  pulse; begin a new matrix pass (honoured in IDLE only).
- flush  in  1  pulse; end input early (honoured in ACC only).
- in_valid  in  1  product beat valid.
- in_ready  out  1  product beat accepted when in_valid && in_ready.
- in_data  in  ACC_WIDTH  product value, two's complement.
- in_row  in  ADDR_WIDTH  row index of product.
- in_last  in  1  final nonzero of matrix.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumer ready.
- out_addr  out  ADDR_WIDTH  row index of result.
- out_data  out  ACC_WIDTH  row sum.
- out_last  out  1  high with the row LENGTH-1 result.
- done  out  1  one-cycle pulse after the final result handshake.
- err  out  1  sticky; a row index went backwards.

Behaviour:
- Reset: state=IDLE, cur_row=0, acc=0; out_valid, in_ready, done, err, out_last = 0; out_addr and out_data = 0.
- Output stage is a single register slot. "Slot free" means !out_valid || out_ready. out_* are held stable while out_valid && !out_ready.
- IDLE: in_ready=0. On start: cur_row=0, acc=0, err cleared, go to ACC.
- ACC, in_valid && in_row==cur_row: in_ready=1; acc<=acc+in_data.
  - If in_last is also set, go to TAIL.
- ACC, in_valid && in_row>cur_row: in_ready=0. When the slot is free, load (cur_row, acc), then cur_row++ and acc=0. This repeats one row per cycle until in_row==cur_row, so gap rows are filled with zeros.
- ACC, in_valid && in_row<cur_row: in_ready=1; beat dropped; err<=1.
- ACC, flush (takes priority over in_valid): go to TAIL without consuming a beat.
- TAIL: in_ready=0. Each free-slot cycle emits (cur_row, acc), then cur_row++ and acc=0, until row LENGTH-1 has been loaded with out_last=1. Then go to DRAIN.
- DRAIN: wait for the out_last handshake. Pulse done for one cycle, then go to IDLE.
- Throughput: 1 beat/cycle within a row. A row change costs ≥1 cycle per emitted row. Result appears on out_* the cycle after it is loaded (registered).
- Arithmetic: acc is ACC_WIDTH, two's complement, wraps on overflow unless the optional feature is enabled.
- start outside IDLE and flush outside ACC are ignored.
- rst_n low in any state returns to the reset values above. An in-flight result is discarded.

Optional Feature:
- Macro: SPMV_ACC_SATURATE_EN.
- Defined: the accumulate clamps to the most-positive (0x7F..F) or most-negative (0x80..0) ACC_WIDTH value on signed overflow.
- Undefined: modular wrap.

Test Plan:
- LENGTH=4; beats (row,data) (0,1)(0,2)(1,3)(1,4)(2,5)(3,6, last) -> outputs (0,3)(1,7)(2,5)(3,6); out_last on row 3; done pulses once; err=0.
- LENGTH=4; beats (0,5)(3,7, last) -> outputs (0,5)(1,0)(2,0)(3,7); in_ready low while rows 1-2 are emitted.
- Case 1 with out_ready held low 5 cycles at row 1 -> out_valid stays 1, out_addr=1 and out_data=7 stable, in_ready=0 until release; no results lost or duplicated.
- Beats (2,4)(1,9) -> (1,9) dropped; err=1 and stays set until the next start; row 2 sum=4.
- ACC_WIDTH=16; beats (0,0x7FFF)(0,0x0001, last) -> row 0 = 0x7FFF with SPMV_ACC_SATURATE_EN, 0x8000 without.
- rst_n low for 1 cycle mid-pass after row 1 emitted -> next cycle out_valid=0, in_ready=0, state IDLE. A new start followed by case 1 reproduces case 1 outputs exactly.
